// File: rtl/msg_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX path between three message sources.
// The granted message is latched and paced out byte by byte with a fixed gap.
module msg_tx_arbiter #(
  parameter int BYTE_GAP = 290,
  parameter int MSG_LEN  = 10
) (
  input  logic                   clk_3125K,
  input  logic                   rst,
  input  logic [2:0]             req,
  input  logic [8*MSG_LEN-1:0]   msg_0,
  input  logic [8*MSG_LEN-1:0]   msg_1,
  input  logic [8*MSG_LEN-1:0]   msg_2,
  input  logic                   tx_busy,
  output logic [7:0]             tx_data,
  output logic                   tx_start,
  output logic [2:0]             grant,
  output logic [2:0]             done,
  output logic                   busy,
  output logic [1:0]             state_dbg
);

  localparam int IDX_W = $clog2(MSG_LEN);
  localparam int GAP_W = $clog2(BYTE_GAP);
  localparam int MSG_W = 8 * MSG_LEN;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MSG_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(BYTE_GAP - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state;
  logic [1:0]         last;
  logic [1:0]         cur_src;
  logic [MSG_W-1:0]   msg_buf;
  logic [IDX_W-1:0]   idx;
  logic [GAP_W-1:0]   gap_cnt;
  logic [1:0]         winner;
  logic [MSG_W-1:0]   sel_msg;
  logic [7:0]         cur_byte;

  // Search order after the last winner: last+1, last+2, then last itself.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] l);
    logic [1:0] a;
    logic [1:0] b;
    a = (l == 2'd0) ? 2'd1 : (l == 2'd1) ? 2'd2 : 2'd0;
    b = (a == 2'd0) ? 2'd1 : (a == 2'd1) ? 2'd2 : 2'd0;
    if (r[a])      return a;
    else if (r[b]) return b;
    else           return l;
  endfunction

  assign winner    = rr_pick(req, last);
  assign cur_byte  = msg_buf[{idx, 3'b000} +: 8];
  assign state_dbg = state;

  always_comb begin
    sel_msg = msg_2;
    case (winner)
      2'd0:    sel_msg = msg_0;
      2'd1:    sel_msg = msg_1;
      default: sel_msg = msg_2;
    endcase
  end

  always_ff @(posedge clk_3125K or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      last     <= 2'd2;
      cur_src  <= 2'd0;
      msg_buf  <= '0;
      idx      <= '0;
      gap_cnt  <= '0;
      tx_data  <= 8'h00;
      tx_start <= 1'b0;
      grant    <= 3'b000;
      done     <= 3'b000;
      busy     <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      done     <= 3'b000;
      case (state)
        IDLE: begin
          busy <= (req != 3'b000);
          if (req != 3'b000) begin
            grant   <= 3'b001 << winner;
            cur_src <= winner;
            msg_buf <= sel_msg;
            idx     <= '0;
            state   <= SEND;
          end
        end
        SEND: begin
          if (!tx_busy) begin
            if (cur_byte == 8'h00) begin
              state <= DONE;
            end else begin
              tx_data  <= cur_byte;
              tx_start <= 1'b1;
              gap_cnt  <= '0;
              state    <= GAP;
            end
          end
        end
        GAP: begin
          // Counter holds at its last value while the UART is still busy.
          if (gap_cnt == GAP_LAST) begin
            if (!tx_busy) begin
              if (idx == IDX_LAST) begin
                state <= DONE;
              end else begin
                idx   <= idx + 1'b1;
                state <= SEND;
              end
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        DONE: begin
          done  <= grant;
          grant <= 3'b000;
          last  <= cur_src;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msg_tx_arbiter.sv
// Bench for msg_tx_arbiter: a reference model queues expected grant/byte/done
// events with their nominal spacing; a monitor pops and compares them.
module tb_msg_tx_arbiter;

  localparam int BYTE_GAP = 290;
  localparam int MSG_LEN  = 10;
  localparam int W        = 22;
  localparam logic [1:0] K_GRANT = 2'd0;
  localparam logic [1:0] K_BYTE  = 2'd1;
  localparam logic [1:0] K_DONE  = 2'd2;

  logic        clk_3125K = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  req = 3'b000;
  logic [79:0] m0 = '0;
  logic [79:0] m1 = '0;
  logic [79:0] m2 = '0;
  logic        tx_busy = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic [2:0]  grant;
  logic [2:0]  done;
  logic        busy;
  logic [1:0]  state_dbg;

  // event word: [21:20] kind, [19:18] source, [17:10] byte, [9:0] nominal delay (0 = unchecked)
  logic [W-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  int model_last = 2;
  logic rand_busy = 1'b0;

  msg_tx_arbiter #(.BYTE_GAP(BYTE_GAP), .MSG_LEN(MSG_LEN)) dut (
    .clk_3125K(clk_3125K), .rst(rst), .req(req),
    .msg_0(m0), .msg_1(m1), .msg_2(m2),
    .tx_busy(tx_busy), .tx_data(tx_data), .tx_start(tx_start),
    .grant(grant), .done(done), .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk_3125K = ~clk_3125K;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_ge(input string name, input int act, input int lo);
    checks++;
    if (act < lo) begin
      errors++;
      $display("FAIL %s: got %0d expected at least %0d", name, act, lo);
    end
  endtask

  function automatic logic [79:0] str_msg(input string s);
    logic [79:0] v;
    v = '0;
    for (int k = 0; k < s.len() && k < MSG_LEN; k++) v[8*k +: 8] = s[k];
    return v;
  endfunction

  function automatic logic [79:0] get_msg(input int s);
    if (s == 0) return m0;
    if (s == 1) return m1;
    return m2;
  endfunction

  task automatic set_msg(input int s, input logic [79:0] v);
    if (s == 0) m0 = v;
    else if (s == 1) m1 = v;
    else m2 = v;
  endtask

  function automatic int model_pick(input logic [2:0] r, input int l);
    for (int k = 1; k <= 3; k++) if (r[(l + k) % 3]) return (l + k) % 3;
    return -1;
  endfunction

  function automatic logic [W-1:0] mk(input logic [1:0] kind, input int src,
                                      input logic [7:0] b, input int dly);
    logic [1:0] s2;
    s2 = 2'(src);
    return {kind, s2, b, 10'(dly)};
  endfunction

  // Reference model: n consecutive grants with request pattern r held.
  task automatic push_expect(input logic [2:0] r, input int n);
    int w;
    int sent;
    logic fin;
    logic [79:0] mm;
    logic [7:0] b;
    for (int g = 0; g < n; g++) begin
      w = model_pick(r, model_last);
      mm = get_msg(w);
      sent = 0;
      fin = 1'b0;
      exp_q.push_back(mk(K_GRANT, w, 8'h00, 0));
      for (int k = 0; k < MSG_LEN && !fin; k++) begin
        b = mm[8*k +: 8];
        if (b == 8'h00) begin
          exp_q.push_back(mk(K_DONE, w, 8'h00, (sent == 0) ? 2 : BYTE_GAP + 2));
          fin = 1'b1;
        end else begin
          exp_q.push_back(mk(K_BYTE, w, b, (sent == 0) ? 1 : BYTE_GAP + 1));
          sent++;
        end
      end
      if (!fin) exp_q.push_back(mk(K_DONE, w, 8'h00, BYTE_GAP + 1));
      model_last = w;
    end
  endtask

  // driver tasks
  task automatic start_req(input logic [2:0] r, input int n);
    int got;
    logic [2:0] prev;
    @(negedge clk_3125K);
    push_expect(r, n);
    req = r;
    got = 0;
    prev = grant;
    for (int c = 0; c < n * 4000 && got < n; c++) begin
      @(negedge clk_3125K);
      if (grant != 3'b000 && prev == 3'b000) got++;
      prev = grant;
    end
    req = 3'b000;
    check("grants_seen", 32'(got), 32'(n));
  endtask

  task automatic wait_starts(input int n);
    int got;
    got = 0;
    for (int c = 0; c < n * 2000 && got < n; c++) begin
      @(negedge clk_3125K);
      if (tx_start) got++;
    end
    check("starts_seen", 32'(got), 32'(n));
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while ((exp_q.size() != 0 || busy) && c < 6000) begin
      @(negedge clk_3125K);
      c++;
    end
    check("drain_in_time", 32'(exp_q.size() == 0 && !busy), 32'd1);
    exp_q.delete();
  endtask

  function automatic logic [79:0] rand_msg();
    logic [79:0] v;
    int len;
    for (int k = 0; k < MSG_LEN; k++) v[8*k +: 8] = 8'($urandom_range(1, 255));
    len = $urandom_range(0, MSG_LEN);
    if (len < MSG_LEN) v[8*len +: 8] = 8'h00;
    return v;
  endfunction

  initial begin
    forever begin
      @(posedge clk_3125K);
      #2;
      if (rand_busy) tx_busy = ($urandom_range(0, 7) == 0);
    end
  end

  // monitor / scoreboard
  initial begin
    int cyc;
    int last_cyc;
    logic stalled;
    logic prev_busy;
    logic [2:0] prev_grant;
    logic [2:0] prev_done;
    logic [W-1:0] e;
    cyc = 0; last_cyc = 0; stalled = 1'b0; prev_busy = 1'b0;
    prev_grant = '0; prev_done = '0; e = '0;
    forever begin
      @(negedge clk_3125K);
      cyc++;
      if (!rst) begin
        prev_grant = '0; prev_done = '0; prev_busy = 1'b0; stalled = 1'b0;
        continue;
      end
      stalled |= prev_busy;
      if (prev_done != 3'b000) check("busy_after_done", 32'(busy), 32'(grant != 3'b000));
      if (grant != 3'b000 && prev_grant == 3'b000) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_grant: got %0b expected none", grant);
        end else begin
          e = exp_q.pop_front();
          check("event_kind_grant", 32'(e[21:20]), 32'(K_GRANT));
          check("grant", 32'(grant), 32'(3'b001 << e[19:18]));
          check("busy_with_grant", 32'(busy), 32'd1);
        end
        last_cyc = cyc; stalled = 1'b0;
      end
      if (tx_start) begin
        check("start_while_tx_busy", 32'(prev_busy), 32'd0);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_byte: got %0h expected none", tx_data);
        end else begin
          e = exp_q.pop_front();
          check("event_kind_byte", 32'(e[21:20]), 32'(K_BYTE));
          check("tx_data", 32'(tx_data), 32'(e[17:10]));
          check("grant_during_byte", 32'(grant), 32'(3'b001 << e[19:18]));
          if (stalled) check_ge("byte_spacing_stalled", cyc - last_cyc, int'(e[9:0]));
          else check("byte_spacing", 32'(cyc - last_cyc), 32'(e[9:0]));
        end
        last_cyc = cyc; stalled = 1'b0;
      end
      if (done != 3'b000) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got %0b expected none", done);
        end else begin
          e = exp_q.pop_front();
          check("event_kind_done", 32'(e[21:20]), 32'(K_DONE));
          check("done", 32'(done), 32'(3'b001 << e[19:18]));
          check("grant_at_done", 32'(grant), 32'd0);
          if (stalled) check_ge("done_delay_stalled", cyc - last_cyc, int'(e[9:0]));
          else check("done_delay", 32'(cyc - last_cyc), 32'(e[9:0]));
        end
        last_cyc = cyc; stalled = 1'b0;
      end
      prev_grant = grant; prev_done = done; prev_busy = tx_busy;
    end
  end

  // stimulus
  initial begin
    logic [79:0] mm;
    repeat (3) @(negedge clk_3125K);
    check("reset_tx_data", 32'(tx_data), 32'h00);
    check("reset_tx_start", 32'(tx_start), 32'd0);
    check("reset_grant", 32'(grant), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_state", 32'(state_dbg), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk_3125K);

    // round-robin contention with all requests held
    set_msg(0, str_msg("AB")); set_msg(1, str_msg("CD")); set_msg(2, str_msg("EF"));
    start_req(3'b111, 4);
    wait_drain();

    // single full-length message
    set_msg(0, str_msg("HELLO_WRLD"));
    start_req(3'b001, 1);
    wait_drain();

    // NUL terminator after two bytes, garbage beyond it
    mm = str_msg("HIzQRSTUVW");
    mm[23:16] = 8'h00;
    set_msg(1, mm);
    start_req(3'b010, 1);
    wait_drain();

    // long tx_busy stall after byte 3
    set_msg(0, str_msg("STALL_TEST"));
    start_req(3'b001, 1);
    wait_starts(3);
    @(posedge clk_3125K); #2 tx_busy = 1'b1;
    repeat (500) @(posedge clk_3125K);
    #2 tx_busy = 1'b0;
    wait_drain();

    // message input changes mid-service
    set_msg(0, str_msg("CHANGE_ME!"));
    start_req(3'b001, 1);
    wait_starts(2);
    set_msg(0, str_msg("zzzzzzzzzz"));
    wait_drain();

    // reset during byte 4
    set_msg(0, str_msg("RESET_MID!"));
    start_req(3'b001, 1);
    wait_starts(4);
    repeat (100) @(negedge clk_3125K);
    @(posedge clk_3125K); #2 rst = 1'b0;
    #1;
    check("midreset_tx_data", 32'(tx_data), 32'h00);
    check("midreset_tx_start", 32'(tx_start), 32'd0);
    check("midreset_grant", 32'(grant), 32'd0);
    check("midreset_done", 32'(done), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_state", 32'(state_dbg), 32'd0);
    exp_q.delete();
    model_last = 2;
    repeat (3) @(negedge clk_3125K);
    rst = 1'b1;
    set_msg(0, str_msg("AFTER_RST0"));
    set_msg(1, str_msg("SOURCE_ONE"));
    start_req(3'b011, 1);
    wait_drain();

    // randomized requests, messages and UART back-pressure
    for (int j = 0; j < 6; j++) begin
      for (int s = 0; s < 3; s++) set_msg(s, rand_msg());
      rand_busy = (j % 2 == 1);
      start_req(3'($urandom_range(1, 7)), $urandom_range(1, 2));
      wait_drain();
      rand_busy = 1'b0;
      @(posedge clk_3125K); #3 tx_busy = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
